// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, stall encodings and FSM states for the pipeline controller.
// Optional watchdog is enabled with PIPE_CTRL_WDOG_EN.
package pipe_ctrl_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] EXC_ERET  = 32'h0000_000e;

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  typedef enum logic {
    RUN  = 1'b0,
    MASK = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/pipe_stall_enc.sv
// Priority encoder from per-stage stall requests to the 6-bit stall vector.
// The deepest requesting stage wins.
module pipe_stall_enc
  import pipe_ctrl_pkg::*;
(
  input  logic       stallreq_if,
  input  logic       stallreq_id,
  input  logic       stallreq_ex,
  input  logic       stallreq_mem,
  output logic [5:0] stall
);

  always_comb begin
    stall = STALL_NONE;
    priority case (1'b1)
      stallreq_mem: stall = STALL_MEM;
      stallreq_ex:  stall = STALL_EX;
      stallreq_id:  stall = STALL_ID;
      stallreq_if:  stall = STALL_IF;
      default:      stall = STALL_NONE;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall merge, exception/eret flush with one-cycle mask.
// Define PIPE_CTRL_WDOG_EN to build the sticky stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [7:0]  WDOG_LIMIT = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        wdog_o
);

  ctrl_state_t state, state_nxt;
  logic [5:0]  stall_enc;

  pipe_stall_enc u_enc (
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .stall        (stall_enc)
  );

  // rst_n is active-high despite its name
  always_ff @(posedge clk) begin
    if (rst_n) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    flush     = 1'b0;
    new_pc    = ZERO_WORD;
    stall     = stall_enc;
    unique case (state)
      RUN: begin
        if (excepttype_i != ZERO_WORD) begin
          flush     = 1'b1;
          stall     = STALL_NONE;
          new_pc    = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
          state_nxt = MASK;
        end
      end
      MASK: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

`ifdef PIPE_CTRL_WDOG_EN
  logic [7:0] wdog_cnt, wdog_cnt_nxt;

  always_comb begin
    wdog_cnt_nxt = wdog_cnt;
    if (!stall[0] || flush)          wdog_cnt_nxt = 8'd0;
    else if (wdog_cnt < WDOG_LIMIT)  wdog_cnt_nxt = wdog_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wdog_cnt <= 8'd0;
      wdog_o   <= 1'b0;
    end else begin
      wdog_cnt <= wdog_cnt_nxt;
      if (wdog_cnt_nxt == WDOG_LIMIT) wdog_o <= 1'b1;
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_LIMIT;
  assign wdog_o      = 1'b0;
`endif

endmodule
